// File: rtl/i2c_slave_core.sv
// I2C slave core: 7-bit addressed target with byte-wide receive pulse, transmit
// valid/ready capture and SCL stretching while no transmit byte is available.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_LOAD  = 3'd5,
        RD_DATA  = 3'd6,
        RD_ACK   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [NS:0] scl_sync_q, sda_sync_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rw_q, rw_d;
    logic        ack_q, ack_d;
    logic        sda_out_q, sda_out_d;
    logic        scl_out_q, scl_out_d;
    logic        rx_valid_q, rx_valid_d;
    logic        start_det_q, start_det_d;
    logic        stop_det_q, stop_det_d;
    logic        busy_q, busy_d;

    // Index NS-1 is the last synchronizer stage, index NS the extra delay flop.
    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_now    = scl_sync_q[NS-1];
    assign scl_prev   = scl_sync_q[NS];
    assign sda_now    = sda_sync_q[NS-1];
    assign sda_prev   = sda_sync_q[NS];
    assign scl_rise   = scl_now & ~scl_prev;
    assign scl_fall   = ~scl_now & scl_prev;
    assign start_cond = scl_now & sda_prev & ~sda_now;
    assign stop_cond  = scl_now & ~sda_prev & sda_now;

    // Handshakes: a transmit byte transfers in the cycle where tx_valid and
    // tx_ready are both high (tx_ready is only raised while tx_valid is high);
    // rx_valid is a single-cycle notification with no back-pressure.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_out_d   = sda_out_q;
        scl_out_d   = scl_out_q;
        rx_valid_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        busy_d      = busy_q;
        tx_ready    = 1'b0;
        if (start_cond) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            ack_d       = 1'b0;
            sda_out_d   = 1'b1;
            scl_out_d   = 1'b1;
            start_det_d = 1'b1;
        end else if (stop_cond) begin
            state_d    = IDLE;
            ack_d      = 1'b0;
            sda_out_d  = 1'b1;
            scl_out_d  = 1'b1;
            stop_det_d = 1'b1;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_now};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shift_q[6:0] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = sda_now;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // ack_q marks that the ACK low phase has begun.
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!ack_q) begin
                        ack_d     = 1'b1;
                        sda_out_d = 1'b0;
                    end else begin
                        ack_d     = 1'b0;
                        sda_out_d = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = (state_q == WR_ACK || !rw_q) ? WR_DATA : RD_LOAD;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_now};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shift_q[6:0], sda_now};
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
                RD_LOAD: if (tx_valid) begin
                    tx_ready  = 1'b1;
                    shift_d   = {tx_data[6:0], 1'b0};
                    sda_out_d = tx_data[7];
                    scl_out_d = 1'b1;
                    bit_cnt_d = 3'd0;
                    state_d   = RD_DATA;
                end else begin
                    scl_out_d = 1'b0;
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = RD_ACK;
                    end else begin
                        sda_out_d = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_now) ack_d = 1'b1;
                    else          state_d = IDLE;
                end else if (scl_fall && ack_q) begin
                    ack_d   = 1'b0;
                    state_d = RD_LOAD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_out_q   <= 1'b1;
            scl_out_q   <= 1'b1;
            rx_valid_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= {scl_sync_q[NS-1:0], scl_in};
            sda_sync_q  <= {sda_sync_q[NS-1:0], sda_in};
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_out_q   <= sda_out_d;
            scl_out_q   <= scl_out_d;
            rx_valid_q  <= rx_valid_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            busy_q      <= busy_d;
        end
    end

    assign scl_out     = scl_out_q;
    assign sda_out     = sda_out_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign start_det   = start_det_q;
    assign stop_det    = stop_det_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
